dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_lane_align.sv | 67 ++++++
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3 codes,
// FSM state type and latency counter width.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // Wide enough for the maximum latency of 15.
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for stores and load extraction/extension for loads.
// Misaligned-access trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext,
    output logic        err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        illegal;

    // Without trapping, half accesses ignore addr[0] and word accesses ignore addr[1:0].
    assign byte_sel = rword[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        be        = 4'b0000;
        wdata_sh  = 32'h0;
        rdata_ext = 32'h0;
        illegal   = 1'b0;
        if (we) begin
            case (funct3)
                F3_B: begin
                    be       = 4'b0001 << addr_lo;
                    wdata_sh = {4{wdata[7:0]}};
                end
                F3_H: begin
                    be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_sh = {2{wdata[15:0]}};
                end
                F3_W: begin
                    be       = 4'b1111;
                    wdata_sh = wdata;
                end
                default: illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_B:    rdata_ext = {{24{byte_sel[7]}}, byte_sel};
                F3_BU:   rdata_ext = {24'h0, byte_sel};
                F3_H:    rdata_ext = {{16{half_sel[15]}}, half_sel};
                F3_HU:   rdata_ext = {16'h0, half_sel};
                F3_W:    rdata_ext = rword;
                default: illegal   = 1'b1;
            endcase
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0])
                     || ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    assign err = illegal | misaligned;
`else
    assign err = illegal;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one valid/ready request, one response strobe after
// LATENCY cycles. Optional misaligned-access trapping via DMEM_MISALIGN_TRAP_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam logic [CNT_W-1:0] CntInit = CNT_W'(LATENCY - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                capture;
    logic                we_q;
    logic [2:0]          funct3_q;
    logic [ADDR_W+1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic [ADDR_W-1:0]   idx;
    logic [DATA_W-1:0]   rword;
    logic [3:0]          be;
    logic [DATA_W-1:0]   wdata_sh;
    logic [DATA_W-1:0]   rdata_ext;
    logic                err;
    logic                wr_en;

    // Upper address bits wrap the word index modulo depth.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    capture = 1'b1;
                    cnt_d   = CntInit;
                    state_d = (LATENCY > 1) ? StWait : StResp;
                end
            end
            StWait: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr[ADDR_W+1:0];
                wdata_q  <= req_wdata;
            end
        end
    end

    assign idx   = addr_q[ADDR_W+1:2];
    assign rword = mem[idx];

    dmem_lane_align u_lane_align (
        .we        (we_q),
        .funct3    (funct3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rword     (rword),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext),
        .err       (err)
    );

    // Store commits on the edge that ends the RESP cycle; an aborted request never gets here.
    assign wr_en = (state_q == StResp) && we_q && !err && !reset;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_err   = (state_q == StResp) && err;
    assign rsp_rdata = ((state_q == StResp) && !we_q && !err) ? rdata_ext : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table of directed transactions plus hand-written
// back-to-back and reset-abort sequences. Honours DMEM_MISALIGN_TRAP_EN.
module tb_dmem_responder;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_W  (32),
        .ADDR_W  (9),
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic [31:0] MisLwData = 32'h0;
    localparam logic        MisErr    = 1'b1;
    localparam logic [31:0] After0x10 = 32'h1234BEEF;
`else
    localparam logic [31:0] MisLwData = 32'h1234BEEF;
    localparam logic        MisErr    = 1'b0;
    localparam logic [31:0] After0x10 = 32'h0;
`endif

    task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic txn(input vec_t v);
        bit seen;
        bit ready_hi;
        int lat;
        @(negedge clk);
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (req_ready) seen = 1'b1;
            else @(negedge clk);
        end
        check_eq({v.name, " accepted"}, 32'(seen), 32'd1);
        if (!seen) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen     = 1'b0;
        ready_hi = 1'b0;
        lat      = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (req_ready) ready_hi = 1'b1;
            if (rsp_valid) seen = 1'b1;
        end
        check_eq({v.name, " latency"}, 32'(lat), 32'(LAT));
        check_eq({v.name, " ready low while busy"}, 32'(ready_hi), 32'd0);
        check_eq({v.name, " rdata"}, rsp_rdata, v.exp_rdata);
        check_eq({v.name, " err"}, 32'(rsp_err), 32'(v.exp_err));
        @(negedge clk);
        check_eq({v.name, " strobe one cycle"}, 32'(rsp_valid), 32'd0);
        check_eq({v.name, " ready again"}, 32'(req_ready), 32'd1);
    endtask

    vec_t vecs[$];
    int   acc[4];
    int   rsp[4];
    int   na;
    int   nr;
    bit   saw_valid;

    initial begin
        vecs.push_back('{"SW 0x10",   1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0, 1'b0});
        vecs.push_back('{"LW 0x10 a", 1'b0, 3'b010, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{"SB 0x13",   1'b1, 3'b000, 32'h13,  32'h000000A5, 32'h0, 1'b0});
        vecs.push_back('{"LW 0x10 b", 1'b0, 3'b010, 32'h10,  32'h0, 32'hA5ADBEEF, 1'b0});
        vecs.push_back('{"LB 0x13",   1'b0, 3'b000, 32'h13,  32'h0, 32'hFFFFFFA5, 1'b0});
        vecs.push_back('{"LBU 0x13",  1'b0, 3'b100, 32'h13,  32'h0, 32'h000000A5, 1'b0});
        vecs.push_back('{"SH 0x12",   1'b1, 3'b001, 32'h12,  32'h00001234, 32'h0, 1'b0});
        vecs.push_back('{"LW 0x10 c", 1'b0, 3'b010, 32'h10,  32'h0, 32'h1234BEEF, 1'b0});
        vecs.push_back('{"LH 0x12",   1'b0, 3'b001, 32'h12,  32'h0, 32'h00001234, 1'b0});
        vecs.push_back('{"LH 0x10",   1'b0, 3'b001, 32'h10,  32'h0, 32'hFFFFBEEF, 1'b0});
        vecs.push_back('{"LHU 0x10",  1'b0, 3'b101, 32'h10,  32'h0, 32'h0000BEEF, 1'b0});
        vecs.push_back('{"LW 0x11",   1'b0, 3'b010, 32'h11,  32'h0, MisLwData, MisErr});
        vecs.push_back('{"SW 0x11",   1'b1, 3'b010, 32'h11,  32'h0, 32'h0, MisErr});
        vecs.push_back('{"LW 0x10 d", 1'b0, 3'b010, 32'h10,  32'h0, After0x10, 1'b0});
        vecs.push_back('{"LD f3=011", 1'b0, 3'b011, 32'h10,  32'h0, 32'h0, 1'b1});
        vecs.push_back('{"ST f3=100", 1'b1, 3'b100, 32'h10,  32'hFFFFFFFF, 32'h0, 1'b1});
        vecs.push_back('{"LW 0x10 e", 1'b0, 3'b010, 32'h10,  32'h0, After0x10, 1'b0});
        vecs.push_back('{"SW 0x810",  1'b1, 3'b010, 32'h810, 32'h11223344, 32'h0, 1'b0});
        vecs.push_back('{"LW wrap",   1'b0, 3'b010, 32'h10,  32'h0, 32'h11223344, 1'b0});
        vecs.push_back('{"LB 0x11",   1'b0, 3'b000, 32'h11,  32'h0, 32'h00000033, 1'b0});
        vecs.push_back('{"SW 0x20",   1'b1, 3'b010, 32'h20,  32'h01020304, 32'h0, 1'b0});

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("reset req_ready", 32'(req_ready), 32'd1);
        check_eq("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset rsp_rdata", rsp_rdata, 32'h0);
        check_eq("reset rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) txn(vecs[i]);

        // Back-to-back loads with req_valid held high.
        @(negedge clk);
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_valid  = 1'b1;
        na = 0;
        nr = 0;
        for (int c = 0; c < 14; c++) begin
            if (req_ready && req_valid && na < 4) begin
                acc[na] = c;
                na++;
            end
            if (rsp_valid && nr < 4) begin
                rsp[nr] = c;
                nr++;
                check_eq("b2b rdata", rsp_rdata, 32'h11223344);
            end
            @(posedge clk);
            #1 if (na == 3) req_valid = 1'b0;
            @(negedge clk);
        end
        check_eq("b2b accept count", 32'(na), 32'd3);
        check_eq("b2b response count", 32'(nr), 32'd3);
        if (na == 3 && nr == 3) begin
            check_eq("b2b accept 2 spacing", 32'(acc[1] - acc[0]), 32'd3);
            check_eq("b2b accept 3 spacing", 32'(acc[2] - acc[0]), 32'd6);
            for (int k = 0; k < 3; k++) begin
                check_eq("b2b response timing", 32'(rsp[k] - acc[k]), 32'(LAT));
            end
        end

        // Reset during WAIT discards the pending store.
        @(negedge clk);
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'hCAFEF00D;
        req_valid  = 1'b1;
        check_eq("abort ready before accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        saw_valid = rsp_valid;
        reset = 1'b1;
        @(negedge clk);
        saw_valid = saw_valid | rsp_valid;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            saw_valid = saw_valid | rsp_valid;
        end
        check_eq("abort no rsp_valid", 32'(saw_valid), 32'd0);
        check_eq("abort ready after release", 32'(req_ready), 32'd1);
        check_eq("abort rdata idle", rsp_rdata, 32'h0);
        txn('{"LW 0x20 after abort", 1'b0, 3'b010, 32'h20, 32'h0, 32'h01020304, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
